// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per enabled clock, LSB first.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_SIGNED_OVF_EN.
module bit_serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;

    logic bit_a, bit_b, bit_d, bit_br;
    logic accept, finish;

    // Single full-subtractor cell working on the LSBs of the operand shifters.
    assign bit_a  = a_q[0];
    assign bit_b  = b_q[0];
    assign bit_d  = bit_a ^ bit_b ^ br_q;
    assign bit_br = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);

    assign accept = en & start & (state_q == IDLE);
    assign finish = en & (state_q == SHIFT) & (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        d_d     = d_q;
        bout_d  = bout_q;
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_d     = A;
                        b_d     = B;
                        br_d    = Bin;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    a_d   = a_q >> 1;
                    b_d   = b_q >> 1;
                    res_d = {bit_d, res_q[WIDTH-1:1]};
                    br_d  = bit_br;
                    cnt_d = cnt_q + CW'(1);
                    if (finish) begin
                        cnt_d   = '0;
                        d_d     = {bit_d, res_q[WIDTH-1:1]};
                        bout_d  = bit_br;
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign D    = d_q;
    assign Bout = bout_q;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    // Operand sign bits are shifted out of a_q/b_q, so keep a copy for the flag.
    logic a_msb_q, b_msb_q, ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_msb_q <= A[WIDTH-1];
                b_msb_q <= B[WIDTH-1];
            end
            if (finish) begin
                ovf_q <= (a_msb_q ^ b_msb_q) & (bit_d ^ a_msb_q);
            end
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed self-checking bench for bit_serial_subtractor (WIDTH=4).
module tb_bit_serial_subtractor;

    localparam int W = 4;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Bin = 1'b0;
    logic         busy, done, Bout, ovf;
    logic [W-1:0] D;

    int errors = 0;
    int checks = 0;

    bit_serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start),
        .A(A), .B(B), .Bin(Bin),
        .busy(busy), .done(done), .D(D), .Bout(Bout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Drives one operation; lat = enabled edges from start edge to done cycle,
    // bcnt = number of cycles busy was observed high.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         output int lat, output int bcnt);
        @(negedge clk);
        A = a; B = b; Bin = bin; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        lat = 1; bcnt = 0;
        while (!done && lat < 50) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (busy) bcnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({busy, done, D, Bout, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b D=%0d Bout=%b ovf=%b, want all 0",
                     busy, done, D, Bout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat, bcnt;
        do_op(4'd5, 4'd3, 1'b0, lat, bcnt);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d edges, want 5", lat); end
        checks++;
        if (bcnt !== 5) begin errors++; $display("FAIL basic_busy_cycles: got %0d, want 5", bcnt); end
        checks++;
        if (D !== 4'd2 || Bout !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL basic_5m3: got D=%0d Bout=%b ovf=%b, want D=2 Bout=0 ovf=0", D, Bout, ovf);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL basic_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
        $display("op 5-3-0: D=%0d Bout=%b lat=%0d", D, Bout, lat);
    endtask

    task automatic test_borrow();
        int lat, bcnt;
        do_op(4'd3, 4'd5, 1'b0, lat, bcnt);
        checks++;
        if (D !== 4'd14 || Bout !== 1'b1 || ovf !== 1'b0) begin
            errors++; $display("FAIL borrow_3m5: got D=%0d Bout=%b ovf=%b, want D=14 Bout=1 ovf=0", D, Bout, ovf);
        end
        $display("op 3-5-0: D=%0d Bout=%b", D, Bout);
        do_op(4'd0, 4'd0, 1'b1, lat, bcnt);
        checks++;
        if (D !== 4'd15 || Bout !== 1'b1 || ovf !== 1'b0) begin
            errors++; $display("FAIL borrow_0m0m1: got D=%0d Bout=%b ovf=%b, want D=15 Bout=1 ovf=0", D, Bout, ovf);
        end
        $display("op 0-0-1: D=%0d Bout=%b", D, Bout);
    endtask

    task automatic test_stall();
        int lat;
        logic [W-1:0] d_hold;
        @(negedge clk);
        d_hold = D;
        A = 4'd6; B = 4'd6; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 1;
        while (!done && lat < 50) begin
            // edges 3..5 (after bits 0 and 1) are stalled
            en = (lat >= 3 && lat < 6) ? 1'b0 : 1'b1;
            @(negedge clk);
            lat++;
            if (lat >= 4 && lat <= 6) begin
                checks++;
                if (D !== d_hold || busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold: got D=%0d busy=%b done=%b, want D=%0d busy=1 done=0",
                             D, busy, done, d_hold);
                end
            end
        end
        en = 1'b1;
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL stall_latency: got %0d edges, want 8", lat); end
        checks++;
        if (D !== 4'd0 || Bout !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL stall_6m6: got D=%0d Bout=%b ovf=%b, want 0 0 0", D, Bout, ovf);
        end
        en = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL done_stretch: got done=%b, want 1", done); end
        en = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL stall_release: got done=%b busy=%b, want 0 0", done, busy);
        end
        $display("op 6-6-0 stalled: D=%0d Bout=%b lat=%0d", D, Bout, lat);
    endtask

    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        A = 4'd9; B = 4'd2; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = '0; B = '0; lat = 1;
        while (!done && lat < 50) begin
            if (lat == 2) begin start = 1'b1; A = 4'd1; B = 4'd1; end
            else start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checks++;
        if (D !== 4'd7 || Bout !== 1'b0 || ovf !== OVF_EN || lat !== 5) begin
            errors++;
            $display("FAIL ignore_start_9m2: got D=%0d Bout=%b ovf=%b lat=%0d, want D=7 Bout=0 ovf=%b lat=5",
                     D, Bout, ovf, lat, OVF_EN);
        end
        $display("op 9-2-0 (mid start ignored): D=%0d Bout=%b ovf=%b", D, Bout, ovf);
    endtask

    task automatic test_mid_reset();
        int lat, bcnt;
        @(negedge clk);
        A = 4'd15; B = 4'd1; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, D, Bout, ovf} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b done=%b D=%0d Bout=%b ovf=%b, want all 0",
                     busy, done, D, Bout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(4'd10, 4'd4, 1'b0, lat, bcnt);
        checks++;
        if (D !== 4'd6 || Bout !== 1'b0 || ovf !== OVF_EN || lat !== 5) begin
            errors++;
            $display("FAIL post_reset_10m4: got D=%0d Bout=%b ovf=%b lat=%0d, want D=6 Bout=0 ovf=%b lat=5",
                     D, Bout, ovf, lat, OVF_EN);
        end
        $display("op 10-4-0 after reset: D=%0d Bout=%b ovf=%b", D, Bout, ovf);
    endtask

    task automatic test_ovf();
        int lat, bcnt;
        do_op(4'd8, 4'd1, 1'b0, lat, bcnt);
        checks++;
        if (D !== 4'd7 || Bout !== 1'b0 || ovf !== OVF_EN) begin
            errors++; $display("FAIL ovf_8m1: got D=%0d Bout=%b ovf=%b, want D=7 Bout=0 ovf=%b", D, Bout, ovf, OVF_EN);
        end
        $display("op 8-1-0: D=%0d Bout=%b ovf=%b", D, Bout, ovf);
        do_op(4'd4, 4'd1, 1'b0, lat, bcnt);
        checks++;
        if (D !== 4'd3 || Bout !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_4m1: got D=%0d Bout=%b ovf=%b, want D=3 Bout=0 ovf=0", D, Bout, ovf);
        end
        $display("op 4-1-0: D=%0d Bout=%b ovf=%b", D, Bout, ovf);
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        A = 4'd12; B = 4'd5; Bin = 1'b1; start = 1'b1;
        @(negedge clk);
        lat = 1;
        while (!done && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (D !== 4'd6 || Bout !== 1'b0 || lat !== 5) begin
            errors++; $display("FAIL b2b_12m5m1: got D=%0d Bout=%b lat=%0d, want D=6 Bout=0 lat=5", D, Bout, lat);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy=%b, want 0", busy); end
        A = 4'd2; B = 4'd7; Bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b, want 1", busy); end
        lat = 1;
        while (!done && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (D !== 4'd11 || Bout !== 1'b1 || ovf !== 1'b0) begin
            errors++; $display("FAIL b2b_2m7: got D=%0d Bout=%b ovf=%b, want D=11 Bout=1 ovf=0", D, Bout, ovf);
        end
        $display("op back-to-back 12-5-1 then 2-7-0: D=%0d Bout=%b", D, Bout);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_stall();
        test_ignore_start();
        test_mid_reset();
        test_ovf();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
